// File: rtl/sd_drive_arbiter.sv
// One FDC sector request at a time, steered to one of NDRIVES hps_io SD ports; strobes and status are registered, buffer routing is 0-cycle.
// A req is taken only in IDLE (no queueing); `define SD_ARB_STATS_EN adds per-drive success counters (stat_count/stat_clr).
module sd_drive_arbiter #(
  parameter int NDRIVES = 2,
  parameter int DRV_W   = (NDRIVES > 1) ? $clog2(NDRIVES) : 1,
  parameter int BUF_AW  = 9,
  parameter int TO_W    = 24
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  req_we,
  input  logic [DRV_W-1:0]      req_drive,
  input  logic [31:0]           req_lba,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [BUF_AW-1:0]     fdc_buff_addr,
  output logic [7:0]            fdc_buff_dout,
  output logic                  fdc_buff_wr,
  input  logic [7:0]            fdc_buff_din,
  input  logic [NDRIVES-1:0]    img_mounted,
  input  logic                  img_readonly,
  input  logic [63:0]           img_size,
  output logic [NDRIVES-1:0]    mounted,
  output logic [32*NDRIVES-1:0] sd_lba,
  output logic [NDRIVES-1:0]    sd_rd,
  output logic [NDRIVES-1:0]    sd_wr,
  input  logic [NDRIVES-1:0]    sd_ack,
  input  logic [BUF_AW-1:0]     sd_buff_addr,
  input  logic [7:0]            sd_buff_dout,
  output logic [8*NDRIVES-1:0]  sd_buff_din,
  input  logic                  sd_buff_wr
`ifdef SD_ARB_STATS_EN
  ,
  output logic [16*NDRIVES-1:0] stat_count,
  input  logic                  stat_clr
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;
  state_t state, state_nxt;

  logic [NDRIVES-1:0] ro;
  logic [DRV_W-1:0]   drv;
  logic               we;
  logic [TO_W-1:0]    to_cnt;

  logic drv_in_range, ack_sel, timeout;
  logic accept, rej_unmounted, rej_readonly, finish, tmo_err;

  assign drv_in_range = ({{(32-DRV_W){1'b0}}, req_drive} < 32'(NDRIVES));
  assign ack_sel      = sd_ack[drv];
  assign timeout      = &to_cnt;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    rej_unmounted = 1'b0;
    rej_readonly  = 1'b0;
    finish        = 1'b0;
    tmo_err       = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (!drv_in_range || !mounted[req_drive]) begin
            rej_unmounted = 1'b1;
          end else if (req_we && ro[req_drive]) begin
            rej_readonly = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (timeout) begin
          tmo_err   = 1'b1;
          state_nxt = S_IDLE;
        end else if (ack_sel) begin
          state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        // A completed handshake wins over a timeout landing on the same cycle.
        if (!ack_sel) begin
          finish    = 1'b1;
          state_nxt = S_IDLE;
        end else if (timeout) begin
          tmo_err   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != S_IDLE);
    sd_rd         = '0;
    sd_wr         = '0;
    fdc_buff_addr = '0;
    fdc_buff_dout = '0;
    fdc_buff_wr   = 1'b0;
    sd_buff_din   = '0;
    if (state == S_REQ) begin
      if (we) sd_wr[drv] = 1'b1;
      else    sd_rd[drv] = 1'b1;
    end
    if (state == S_XFER) begin
      fdc_buff_addr = sd_buff_addr;
      if (!we && ack_sel) begin
        fdc_buff_dout = sd_buff_dout;
        fdc_buff_wr   = sd_buff_wr;
      end
      if (we) sd_buff_din[8*drv +: 8] = fdc_buff_din;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      drv      <= '0;
      we       <= 1'b0;
      to_cnt   <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
      sd_lba   <= '0;
      mounted  <= '0;
      ro       <= '0;
    end else begin
      done <= finish;
      err  <= rej_unmounted | rej_readonly | tmo_err;
      if (accept) begin
        drv                      <= req_drive;
        we                       <= req_we;
        err_code                 <= 2'd0;
        sd_lba[32*req_drive +: 32] <= req_lba;
      end else if (rej_unmounted) begin
        err_code <= 2'd1;
      end else if (rej_readonly) begin
        err_code <= 2'd2;
      end else if (tmo_err) begin
        err_code <= 2'd3;
      end
      // Any buffer strobe proves hps_io is alive, so it restarts the watchdog.
      if (state == S_IDLE || sd_buff_wr) to_cnt <= '0;
      else                               to_cnt <= to_cnt + 1'b1;
      for (int i = 0; i < NDRIVES; i++) begin
        if (img_mounted[i]) begin
          mounted[i] <= |img_size;
          ro[i]      <= img_readonly;
        end
      end
    end
  end

`ifdef SD_ARB_STATS_EN
  logic [15:0] stat_cnt [NDRIVES];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NDRIVES; i++) stat_cnt[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < NDRIVES; i++) stat_cnt[i] <= '0;
    end else if (finish && stat_cnt[drv] != 16'hFFFF) begin
      stat_cnt[drv] <= stat_cnt[drv] + 16'd1;
    end
  end

  always_comb begin
    stat_count = '0;
    for (int i = 0; i < NDRIVES; i++) stat_count[16*i +: 16] = stat_cnt[i];
  end
`endif

endmodule

// File: doc/sd_drive_arbiter.md
Name: sd_drive_arbiter

Overview:
Parametrised N-drive SD-image request arbiter between the floppy controller and the hps_io virtual-disk port. It replaces the fixed two-drive OR-of-acks and shared-LBA wiring in the top level. Per request it drives a single drive's LBA and rd/wr strobe and routes that drive's ack and buffer traffic only. It also tracks per-drive mount and readonly status and reports completion or error back to the controller.

Parameters:
NDRIVES, 2, number of virtual drives (1..4); sizes every per-drive bus
DRV_W, $clog2(NDRIVES) min 1, width of the drive index
BUF_AW, 9, sector buffer address width (512-byte sectors)
TO_W, 24, timeout counter width; timeout = 2^TO_W-1 clk_sys cycles

Ports:
clk_sys  in  1  system clock (42 MHz)
reset  in  1  asynchronous, active-high reset
req  in  1  one-cycle request pulse from FDC; sampled only in IDLE
req_we  in  1  1 = sector write, 0 = sector read; qualified by req
req_drive  in  DRV_W  target drive index; qualified by req
req_lba  in  32  sector LBA; qualified by req
busy  out  1  high from accepted req until done/err pulse
done  out  1  one-cycle pulse on successful completion
err  out  1  one-cycle pulse on a rejected or timed-out request
err_code  out  2  0 none, 1 unmounted, 2 readonly, 3 timeout; held until next req
fdc_buff_addr  out  BUF_AW  buffer address of the active transfer
fdc_buff_dout  out  8  read data toward the FDC sector buffer
fdc_buff_wr  out  1  write strobe into the FDC buffer (reads only)
fdc_buff_din  in  8  FDC buffer data for sector writes
img_mounted  in  NDRIVES  per-drive mount pulse from hps_io
img_readonly  in  1  readonly flag; valid with img_mounted
img_size  in  64  image size; valid with img_mounted
mounted  out  NDRIVES  per-drive mounted status
sd_lba  out  32*NDRIVES  per-drive LBA, drive i at [32*i+:32]
sd_rd  out  NDRIVES  per-drive read request
sd_wr  out  NDRIVES  per-drive write request
sd_ack  in  NDRIVES  per-drive ack from hps_io
sd_buff_addr  in  BUF_AW  hps_io buffer address
sd_buff_dout  in  8  hps_io read data
sd_buff_din  out  8*NDRIVES  write data per drive
sd_buff_wr  in  1  hps_io data strobe

Behaviour:
- Reset values: all outputs 0. State IDLE. mounted and ro are cleared. All sd_lba fields are 0.
- Mount tracking, any state:
  - On img_mounted[i]: mounted[i] <= |img_size; ro[i] <= img_readonly.
  - Several drives pulsing in the same cycle each latch independently.
- IDLE:
  - req with mounted[req_drive]=0: err pulse the next cycle, err_code=1, stay IDLE.
  - req with req_we=1 and ro[req_drive]=1: err pulse, err_code=2, stay IDLE.
  - req_drive >= NDRIVES: treated as unmounted.
  - Otherwise: latch drive, we and lba; busy=1; sd_lba[drive]=lba; go to REQ.
- REQ:
  - Hold sd_rd[drive] (or sd_wr[drive]) high.
  - On sd_ack[drive] rising, drop the strobe in the same edge and go to XFER.
  - Acks from other drives are ignored.
- XFER:
  - fdc_buff_addr follows sd_buff_addr.
  - Read: fdc_buff_dout=sd_buff_dout and fdc_buff_wr=sd_buff_wr, gated by sd_ack[drive], both combinational (0-cycle latency).
  - Write: sd_buff_din[drive]=fdc_buff_din; all other drives' sd_buff_din=0.
  - On sd_ack[drive] falling: done pulse, busy=0, go to IDLE.
- Timeout:
  - The counter clears on entering REQ and is cleared by any sd_buff_wr.
  - At terminal count in REQ or XFER: drop strobes, err pulse, err_code=3, back to IDLE.
- A req arriving while busy is ignored; no queueing.
- Unmount mid-transfer (img_mounted[drive] with size 0):
  - mounted clears immediately.
  - The transfer continues until ack falls or the timeout fires.
- done and err are never high together.

Optional Feature:
SD_ARB_STATS_EN:
- When defined, adds output stat_count [16*NDRIVES] and input stat_clr.
- Per-drive 16-bit counters of successful transfers; they saturate at 16'hFFFF.
- stat_clr zeroes all counters; if stat_clr and done coincide, the clear wins.
- When undefined, neither port nor the counters exist, and the rest of the behaviour is identical.

Test Plan:
- Mount drive 1 with size 0x23000, readonly=0; req drive=1, we=0, lba=5 -> sd_rd=2'b10, sd_lba[63:32]=5; ack high, 512 sd_buff_wr strobes -> 512 fdc_buff_wr with matching data; ack low -> done one cycle, busy 0.
- Same read with a stray sd_ack[0] pulse during REQ -> sd_rd[1] stays high and there is no state change.
- req to drive 0, never mounted -> err next cycle, err_code=1, sd_rd/sd_wr stay 0.
- Mount drive 0 readonly=1; req we=1 -> err_code=2; the same req with we=0 succeeds.
- TO_W=8, req on a mounted drive and ack never arrives -> err at 255 cycles, err_code=3, strobe drops; a following req is accepted.
- Reset asserted mid-XFER -> busy, sd_rd, sd_wr and mounted are all 0 asynchronously; with SD_ARB_STATS_EN, 3 reads on drive 1 -> stat_count[31:16]=3.
